// File: rtl/lc3_pc_sequencer.sv
// Moore sequencer for the LC-3 PC unit and fetch path: fetch, decode, PC redirect
// for control-flow instructions, and hand-off to the execute controller.
module lc3_pc_sequencer #(
  parameter int unsigned MEM_WAIT_MAX = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ir,
  input  logic [2:0]  nzp,
  input  logic        mem_rdy,
  input  logic        exec_done,
  output logic [1:0]  selPC,
  output logic        ldPC,
  output logic        gatePC,
  output logic        gateMDR,
  output logic        gateTRAP,
  output logic        ldMAR,
  output logic        ldIR,
  output logic        ldR7,
  output logic        mem_en,
  output logic [1:0]  eab_mode,
  output logic        exec_start,
  output logic        fault
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MEM_WAIT_MAX);

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RSV  = 4'b1101;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [1:0] SEL_INC = 2'b00;
  localparam logic [1:0] SEL_EAB = 2'b01;
  localparam logic [1:0] SEL_BUS = 2'b10;

  localparam logic [1:0] EAB_OFF9  = 2'b00;
  localparam logic [1:0] EAB_BASE  = 2'b01;
  localparam logic [1:0] EAB_OFF11 = 2'b10;

  typedef enum logic [3:0] {
    S_F_MAR,
    S_F_WAIT,
    S_F_IR,
    S_DECODE,
    S_BR,
    S_JMP,
    S_JSR_LINK,
    S_JSR_TGT,
    S_T_MAR,
    S_T_LINK,
    S_T_WAIT,
    S_T_PC,
    S_EXEC,
    S_EXEC_WAIT,
    S_FAULT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_cnt_inc;

  logic [1:0] w_selPC;
  logic       w_ldPC;
  logic       w_gatePC;
  logic       w_gateMDR;
  logic       w_gateTRAP;
  logic       w_ldMAR;
  logic       w_ldIR;
  logic       w_ldR7;
  logic       w_mem_en;
  logic [1:0] w_eab_mode;
  logic       w_exec_start;
  logic       w_fault;

  // Only the opcode, BR condition and JSR form bits steer the sequencer.
  logic w_ir_unused;
  assign w_ir_unused = ^ir[8:0];

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_F_MAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    unique case (r_state)
      S_F_MAR:  w_next = S_F_WAIT;
      S_F_WAIT, S_T_WAIT: begin
        if (mem_rdy) begin
          w_next = (r_state == S_F_WAIT) ? S_F_IR : S_T_PC;
        end else begin
          w_cnt_next = w_cnt_inc;
          if (w_cnt_inc >= WAIT_MAX) begin
            w_next = S_FAULT;
          end
        end
      end
      S_F_IR:   w_next = S_DECODE;
      S_DECODE: begin
        unique case (ir[15:12])
          OP_BR:   w_next = ((ir[11:9] & nzp) != 3'b000) ? S_BR : S_F_MAR;
          OP_JMP:  w_next = S_JMP;
          OP_JSR:  w_next = S_JSR_LINK;
          OP_TRAP: w_next = S_T_MAR;
          OP_RTI, OP_RSV: w_next = S_FAULT;
          default: w_next = S_EXEC;
        endcase
      end
      S_BR:        w_next = S_F_MAR;
      S_JMP:       w_next = S_F_MAR;
      S_JSR_LINK:  w_next = S_JSR_TGT;
      S_JSR_TGT:   w_next = S_F_MAR;
      S_T_MAR:     w_next = S_T_LINK;
      S_T_LINK:    w_next = S_T_WAIT;
      S_T_PC:      w_next = S_F_MAR;
      S_EXEC:      w_next = S_EXEC_WAIT;
      S_EXEC_WAIT: w_next = exec_done ? S_F_MAR : S_EXEC_WAIT;
      S_FAULT:     w_next = S_FAULT;
      default:     w_next = S_FAULT;
    endcase
    if ((w_next == S_F_WAIT || w_next == S_T_WAIT) && (w_next != r_state)) begin
      w_cnt_next = '0;
    end
  end

  // Moore output decode.
  always_comb begin
    w_selPC      = SEL_INC;
    w_ldPC       = 1'b0;
    w_gatePC     = 1'b0;
    w_gateMDR    = 1'b0;
    w_gateTRAP   = 1'b0;
    w_ldMAR      = 1'b0;
    w_ldIR       = 1'b0;
    w_ldR7       = 1'b0;
    w_mem_en     = 1'b0;
    w_eab_mode   = EAB_OFF9;
    w_exec_start = 1'b0;
    w_fault      = 1'b0;
    unique case (r_state)
      S_F_MAR: begin
        w_gatePC = 1'b1;
        w_ldMAR  = 1'b1;
        w_selPC  = SEL_INC;
        w_ldPC   = 1'b1;
      end
      S_F_WAIT, S_T_WAIT: w_mem_en = 1'b1;
      S_F_IR: begin
        w_gateMDR = 1'b1;
        w_ldIR    = 1'b1;
      end
      S_BR: begin
        w_eab_mode = EAB_OFF9;
        w_selPC    = SEL_EAB;
        w_ldPC     = 1'b1;
      end
      S_JMP: begin
        w_eab_mode = EAB_BASE;
        w_selPC    = SEL_EAB;
        w_ldPC     = 1'b1;
      end
      S_JSR_LINK, S_T_LINK: begin
        w_gatePC = 1'b1;
        w_ldR7   = 1'b1;
      end
      S_JSR_TGT: begin
        w_eab_mode = ir[11] ? EAB_OFF11 : EAB_BASE;
        w_selPC    = SEL_EAB;
        w_ldPC     = 1'b1;
      end
      S_T_MAR: begin
        w_gateTRAP = 1'b1;
        w_ldMAR    = 1'b1;
      end
      S_T_PC: begin
        w_gateMDR = 1'b1;
        w_selPC   = SEL_BUS;
        w_ldPC    = 1'b1;
      end
      S_EXEC:  w_exec_start = 1'b1;
      S_FAULT: w_fault      = 1'b1;
      default: ;
    endcase
  end

  // Outputs are forced low for the whole time reset is held, not just after an edge.
  assign selPC      = w_selPC & {2{reset}};
  assign ldPC       = w_ldPC & reset;
  assign gatePC     = w_gatePC & reset;
  assign gateMDR    = w_gateMDR & reset;
  assign gateTRAP   = w_gateTRAP & reset;
  assign ldMAR      = w_ldMAR & reset;
  assign ldIR       = w_ldIR & reset;
  assign ldR7       = w_ldR7 & reset;
  assign mem_en     = w_mem_en & reset;
  assign eab_mode   = w_eab_mode & {2{reset}};
  assign exec_start = w_exec_start & reset;
  assign fault      = w_fault & reset;

endmodule

// File: tb/tb_lc3_pc_sequencer.sv
// Directed, table-driven bench for lc3_pc_sequencer with hand-coded per-cycle outputs.
`timescale 1ns/1ps
module tb_lc3_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] ir = '0;
  logic [2:0]  nzp = '0;
  logic        mem_rdy = 1'b0;
  logic        exec_done = 1'b0;
  logic [1:0]  selPC;
  logic        ldPC, gatePC, gateMDR, gateTRAP, ldMAR, ldIR, ldR7, mem_en;
  logic [1:0]  eab_mode;
  logic        exec_start, fault;

  lc3_pc_sequencer #(.MEM_WAIT_MAX(4)) dut (
    .clk(clk), .reset(rst), .ir(ir), .nzp(nzp), .mem_rdy(mem_rdy),
    .exec_done(exec_done), .selPC(selPC), .ldPC(ldPC), .gatePC(gatePC),
    .gateMDR(gateMDR), .gateTRAP(gateTRAP), .ldMAR(ldMAR), .ldIR(ldIR),
    .ldR7(ldR7), .mem_en(mem_en), .eab_mode(eab_mode),
    .exec_start(exec_start), .fault(fault)
  );

  always #10 clk = ~clk;

  // {selPC, ldPC, gatePC, gateMDR, gateTRAP, ldMAR, ldIR, ldR7, mem_en, eab_mode, exec_start, fault}
  localparam logic [13:0] E_ZERO  = 14'b00_0_0_0_0_0_0_0_0_00_0_0;
  localparam logic [13:0] E_FMAR  = 14'b00_1_1_0_0_1_0_0_0_00_0_0;
  localparam logic [13:0] E_WAIT  = 14'b00_0_0_0_0_0_0_0_1_00_0_0;
  localparam logic [13:0] E_FIR   = 14'b00_0_0_1_0_0_1_0_0_00_0_0;
  localparam logic [13:0] E_BR    = 14'b01_1_0_0_0_0_0_0_0_00_0_0;
  localparam logic [13:0] E_BASE  = 14'b01_1_0_0_0_0_0_0_0_01_0_0;
  localparam logic [13:0] E_OFF11 = 14'b01_1_0_0_0_0_0_0_0_10_0_0;
  localparam logic [13:0] E_LINK  = 14'b00_0_1_0_0_0_0_1_0_00_0_0;
  localparam logic [13:0] E_TMAR  = 14'b00_0_0_0_1_1_0_0_0_00_0_0;
  localparam logic [13:0] E_TPC   = 14'b10_1_0_1_0_0_0_0_0_00_0_0;
  localparam logic [13:0] E_EXEC  = 14'b00_0_0_0_0_0_0_0_0_00_1_0;
  localparam logic [13:0] E_FAULT = 14'b00_0_0_0_0_0_0_0_0_00_0_1;

  typedef struct {
    logic        rst;
    logic [15:0] ir;
    logic [2:0]  nzp;
    logic        rdy;
    logic        done;
    logic [13:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] b_ir;
  logic [2:0]  b_nzp;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic [13:0] outs();
    return {selPC, ldPC, gatePC, gateMDR, gateTRAP, ldMAR, ldIR, ldR7, mem_en,
            eab_mode, exec_start, fault};
  endfunction

  task automatic add(input logic r, input logic rdy, input logic done, input logic [13:0] e);
    vec_t v;
    v.rst = r; v.ir = b_ir; v.nzp = b_nzp; v.rdy = rdy; v.done = done; v.exp = e;
    vecs.push_back(v);
  endtask

  // Fetch with mem_rdy on the first wait cycle, ending in DECODE of i.
  task automatic fetch(input logic [15:0] i, input logic [2:0] n);
    b_ir = i; b_nzp = n;
    add(1'b1, 1'b1, 1'b0, E_FMAR);
    add(1'b1, 1'b1, 1'b0, E_WAIT);
    add(1'b1, 1'b1, 1'b1, E_FIR);
    add(1'b1, 1'b0, 1'b0, E_ZERO);
  endtask

  task automatic check(input string name, input int idx, input logic [13:0] e);
    logic [13:0] got;
    got = outs();
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s[%0d]: outputs got %b, expected %b", name, idx, got, e);
    end
  endtask

  task automatic check_gates(input int idx);
    n_checks++;
    if ($countones({gatePC, gateMDR, gateTRAP}) > 1) begin
      n_fail++;
      $display("FAIL bus_gates[%0d]: gates {PC,MDR,TRAP} got %b, expected at most one high",
               idx, {gatePC, gateMDR, gateTRAP});
    end
  endtask

  initial begin
    b_ir = 16'h0402; b_nzp = 3'b010;
    // Reset, then three idle wait cycles; mem_rdy on the 4th wins over the timeout.
    add(1'b0, 1'b0, 1'b0, E_ZERO);
    add(1'b0, 1'b0, 1'b0, E_ZERO);
    add(1'b1, 1'b0, 1'b0, E_FMAR);
    repeat (3) add(1'b1, 1'b0, 1'b0, E_WAIT);
    add(1'b1, 1'b1, 1'b0, E_WAIT);
    add(1'b1, 1'b0, 1'b0, E_FIR);
    add(1'b1, 1'b0, 1'b0, E_ZERO);
    add(1'b1, 1'b0, 1'b0, E_BR);
    fetch(16'h0402, 3'b100);                       // BRz not taken
    fetch(16'h4805, 3'b000);                       // JSR
    add(1'b1, 1'b0, 1'b0, E_LINK);
    add(1'b1, 1'b0, 1'b0, E_OFF11);
    fetch(16'h4080, 3'b000);                       // JSRR R2
    add(1'b1, 1'b0, 1'b0, E_LINK);
    add(1'b1, 1'b0, 1'b0, E_BASE);
    fetch(16'hC1C0, 3'b000);                       // RET
    add(1'b1, 1'b0, 1'b0, E_BASE);
    fetch(16'h0000, 3'b111);                       // BR never: NOP
    // TRAP with slow fetch; T_WAIT must restart the count or it would fault.
    b_ir = 16'hF025; b_nzp = 3'b000;
    add(1'b1, 1'b0, 1'b0, E_FMAR);
    repeat (3) add(1'b1, 1'b0, 1'b0, E_WAIT);
    add(1'b1, 1'b1, 1'b0, E_WAIT);
    add(1'b1, 1'b0, 1'b0, E_FIR);
    add(1'b1, 1'b0, 1'b0, E_ZERO);
    add(1'b1, 1'b1, 1'b0, E_TMAR);
    add(1'b1, 1'b1, 1'b0, E_LINK);
    repeat (3) add(1'b1, 1'b0, 1'b0, E_WAIT);
    add(1'b1, 1'b1, 1'b0, E_WAIT);
    add(1'b1, 1'b0, 1'b0, E_TPC);
    fetch(16'h1261, 3'b000);                       // ADD
    add(1'b1, 1'b0, 1'b1, E_EXEC);
    add(1'b1, 1'b0, 1'b0, E_ZERO);
    add(1'b1, 1'b0, 1'b0, E_ZERO);
    add(1'b1, 1'b0, 1'b1, E_ZERO);
    fetch(16'hD000, 3'b000);                       // reserved opcode
    add(1'b1, 1'b1, 1'b1, E_FAULT);
    add(1'b1, 1'b0, 1'b0, E_FAULT);
    add(1'b0, 1'b0, 1'b0, E_ZERO);
    // Timeout: four wait cycles without mem_rdy.
    add(1'b1, 1'b0, 1'b0, E_FMAR);
    repeat (4) add(1'b1, 1'b0, 1'b0, E_WAIT);
    add(1'b1, 1'b0, 1'b0, E_FAULT);
    add(1'b1, 1'b1, 1'b0, E_FAULT);
    add(1'b0, 1'b0, 1'b0, E_ZERO);
    fetch(16'h8000, 3'b000);                       // RTI
    add(1'b1, 1'b0, 1'b0, E_FAULT);
    add(1'b0, 1'b0, 1'b0, E_ZERO);
    fetch(16'h1261, 3'b000);                       // park in EXEC_WAIT
    add(1'b1, 1'b0, 1'b0, E_EXEC);
    add(1'b1, 1'b0, 1'b0, E_ZERO);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; ir = vecs[i].ir; nzp = vecs[i].nzp;
      mem_rdy = vecs[i].rdy; exec_done = vecs[i].done;
      #1;
      check("vec", i, vecs[i].exp);
      check_gates(i);
    end

    // Async reset in EXEC_WAIT, released before any clock edge: F_MAR right away.
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("rst_exec_wait_low", 0, E_ZERO);
    #2 rst = 1'b1;
    #1 check("rst_exec_wait_release", 0, E_FMAR);
    // Async reset while mem_en is held in F_WAIT.
    @(posedge clk);
    #2 check("fwait_before_rst", 0, E_WAIT);
    rst = 1'b0;
    #1 check("rst_fwait_low", 0, E_ZERO);
    @(posedge clk);
    #2 check("rst_held_over_edge", 0, E_ZERO);
    @(negedge clk);
    rst = 1'b1;
    #1 check("rst_fwait_release", 0, E_FMAR);
    @(posedge clk);
    #2 check("after_release_wait", 0, E_WAIT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
